// File: rtl/flags_unit_if.sv
// Interface bundling the flags unit's bus, ALU, stack and condition signals.
// The control side (CPU control unit / testbench) uses the master modport;
// the flags unit itself uses the slave modport.
interface flags_unit_if #(
  parameter int FLAG_W = 4
);
  logic              cs_in;
  logic [FLAG_W-1:0] bus_in;
  logic              alu_we;
  logic [FLAG_W-1:0] alu_mask;
  logic [FLAG_W-1:0] alu_flags;
  logic              push;
  logic              pop;
  logic              eval;
  logic [3:0]        operator;
  logic [FLAG_W-1:0] flags_out;
  logic              check_branch;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output cs_in, bus_in, alu_we, alu_mask, alu_flags,
    output push, pop, eval, operator,
    input  flags_out, check_branch, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  cs_in, bus_in, alu_we, alu_mask, alu_flags,
    input  push, pop, eval, operator,
    output flags_out, check_branch, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flags_unit.sv
// CPU status-flags register with branch-condition evaluator and an
// interrupt save/restore stack. Bits [3:0] hold C, V, Z, N; higher bits are
// software-defined user flags that the condition evaluator ignores.
module flags_unit #(
  parameter int FLAG_W      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 3
) (
  input logic         clk,
  input logic         rst,
  flags_unit_if.slave bus
);

  // Index width for the stack array; at least one bit even for a single entry.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(STACK_DEPTH);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] alu_merge;
  logic [FLAG_W-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_dec;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              check_q;
  logic              err_q;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;
  logic              stack_fault;
  logic              cond;
  logic              flag_c;
  logic              flag_v;
  logic              flag_z;
  logic              flag_n;

  // Occupancy is decoded straight from the registered pointer.
  assign full  = (ptr_q == DEPTH_PTR);
  assign empty = (ptr_q == '0);

  // A push and pop together cancel each other; a push needs room and a pop
  // needs an entry. Any of these illegal requests latches the error flag.
  assign push_ok     = bus.push & ~bus.pop & ~full;
  assign pop_ok      = bus.pop & ~bus.push & ~empty;
  assign stack_fault = (bus.push & bus.pop) | (bus.push & full) | (bus.pop & empty);

  assign ptr_dec = ptr_q - 1'b1;
  assign wr_idx  = ptr_q[IDX_W-1:0];
  assign rd_idx  = ptr_dec[IDX_W-1:0];

  assign alu_merge = (flags_q & ~bus.alu_mask) | (bus.alu_flags & bus.alu_mask);

  assign flag_c = flags_q[0];
  assign flag_v = flags_q[1];
  assign flag_z = flags_q[2];
  assign flag_n = flags_q[3];

  // Next flag value: a valid restore beats a bus write, which beats the ALU.
  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = stack_mem[rd_idx];
    end else if (bus.cs_in) begin
      flags_d = bus.bus_in;
    end else if (bus.alu_we) begin
      flags_d = alu_merge;
    end
  end

  // Branch condition decode on the current (pre-edge) architectural flags.
  always_comb begin
    cond = 1'b0;
    case (bus.operator)
      4'h0: cond = flag_z;
      4'h1: cond = ~flag_z;
      4'h2: cond = flag_c;
      4'h3: cond = ~flag_c;
      4'h4: cond = flag_n;
      4'h5: cond = ~flag_n;
      4'h6: cond = flag_v;
      4'h7: cond = ~flag_v;
      4'h8: cond = flag_c & ~flag_z;
      4'h9: cond = ~flag_c | flag_z;
      4'hA: cond = (flag_n == flag_v);
      4'hB: cond = (flag_n != flag_v);
      4'hC: cond = ~flag_z & (flag_n == flag_v);
      4'hD: cond = flag_z | (flag_n != flag_v);
      4'hE: cond = 1'b1;
      4'hF: cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

  // Stack storage needs no reset; entries are only read below the pointer.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_idx] <= flags_q;
    end
  end

  // Architectural state: flags, stack pointer, branch result and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      ptr_q   <= '0;
      check_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      if (push_ok) begin
        ptr_q <= ptr_q + 1'b1;
      end else if (pop_ok) begin
        ptr_q <= ptr_dec;
      end
      if (bus.eval) begin
        check_q <= cond;
      end
      if (stack_fault) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.flags_out    = flags_q;
  assign bus.check_branch = check_q;
  assign bus.stack_full   = full;
  assign bus.stack_empty  = empty;
  assign bus.stack_err    = err_q;

endmodule
